// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side FIFO: fetch FSM encoding,
// frame-complete marker and the packed FIFO entry layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [3:0] FRAME_BITS = 4'd11;
  localparam int         ENTRY_W    = 10;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  function automatic rx_entry_t pack_entry(input logic fe, input logic pe, input logic [7:0] data);
    rx_entry_t e;
    e.fe   = fe;
    e.pe   = pe;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver-side handshake and CPU read-port signals for uart_rx_fifo.
// slave is the FIFO block's view, master is the surrounding system's view.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);

  logic          r_ready;
  logic          parity_error;
  logic          frame_error;
  logic [3:0]    no_bits_rcvd;
  logic [7:0]    d_out;
  logic          rdn;

  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_pe;
  logic          rd_fe;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          ovr_clr;

  modport slave (
    input  r_ready, parity_error, frame_error, no_bits_rcvd, d_out,
    output rdn,
    input  rd_en, ovr_clr,
    output rd_data, rd_pe, rd_fe, empty, full, count, overrun
  );

  modport master (
    output r_ready, parity_error, frame_error, no_bits_rcvd, d_out,
    input  rdn,
    output rd_en, ovr_clr,
    input  rd_data, rd_pe, rd_fe, empty, full, count, overrun
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with a registered first-word-fall-through head.
// The head register holds its last value while the FIFO is empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_req_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_req_i,
  output logic               wr_ack_o,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [AW:0]        count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [AW:0]        count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = rd_req_i & ~empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push  = wr_req_i & (~full | pop);

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    head_d = head_q;
    if (pop) begin
      if (count_q > CNT_ONE) head_d = mem_q[rptr_d];
      else if (push)         head_d = wr_data_i;
    end else if (push && empty) begin
      head_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign wr_ack_o = push;
  assign head_o   = head_q;
  assign empty_o  = empty;
  assign full_o   = full;
  assign count_o  = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Fetches completed frames from the UART receiver with a one-cycle rdn strobe and
// queues {fe, pe, data} for the CPU, flagging overrun when a byte must be dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk16x,
  input  logic           clr,
  uart_rx_fifo_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic         rdn_q, rdn_d;
  logic         pe_q, pe_d;
  logic         fe_q, fe_d;
  logic         ovr_q, ovr_d;

  logic         fetch_cycle;
  logic         wr_ack;
  rx_entry_t    wr_entry;
  rx_entry_t    head;
  logic [ENTRY_W-1:0] head_raw;
  logic         frame_done;

  assign frame_done  = (bus.no_bits_rcvd == FRAME_BITS);
  assign fetch_cycle = (state_q == FETCH);
  assign wr_entry    = pack_entry(fe_q, pe_q, bus.d_out);

  always_comb begin
    state_d = state_q;
    rdn_d   = 1'b1;
    pe_d    = pe_q;
    fe_d    = fe_q;
    case (state_q)
      IDLE: begin
        // Flags are latched here because the falling rdn clears them in the receiver.
        if (bus.r_ready && frame_done) begin
          pe_d    = bus.parity_error;
          fe_d    = bus.frame_error;
          rdn_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (!frame_done) state_d = FLUSH;
      end
      FLUSH: begin
        // A ready re-raised while the counter still read 11 is stale: discard it.
        if (bus.r_ready) rdn_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ovr_d = (fetch_cycle & ~wr_ack) | (ovr_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      rdn_q   <= 1'b1;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdn_q   <= rdn_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (clk16x),
    .rst_i     (clr),
    .wr_req_i  (fetch_cycle),
    .wr_data_i (wr_entry),
    .rd_req_i  (bus.rd_en),
    .wr_ack_o  (wr_ack),
    .head_o    (head_raw),
    .empty_o   (bus.empty),
    .full_o    (bus.full),
    .count_o   (bus.count)
  );

  assign head        = rx_entry_t'(head_raw);
  assign bus.rdn     = rdn_q;
  assign bus.rd_data = head.data;
  assign bus.rd_pe   = head.pe;
  assign bus.rd_fe   = head.fe;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames against a queue-based reference of the receive FIFO.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk16x = 1'b0;
  logic clr    = 1'b1;
  logic [7:0] rx_byte = 8'h00;

  uart_rx_fifo_if #(.AW(AW)) bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk16x (clk16x),
    .clr    (clr),
    .bus    (bus)
  );

  always #5 clk16x = ~clk16x;

  // Receiver data bus is only meaningful while rdn is low.
  assign bus.d_out = bus.rdn ? 8'hEE : rx_byte;

  int tests    = 0;
  int fails    = 0;
  int rdn_lows = 0;

  logic [9:0] model_q[$];
  logic       model_ovr = 1'b0;
  logic [9:0] held      = 10'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; model the receiver clearing its flags the moment rdn falls.
  task automatic tick();
    @(posedge clk16x);
    #1;
    if (bus.rdn === 1'b0) begin
      rdn_lows++;
      bus.r_ready      = 1'b0;
      bus.parity_error = 1'b0;
      bus.frame_error  = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [9:0] disp;
    disp = (model_q.size() > 0) ? model_q[0] : held;
    chk({tag, ".count"},   32'(bus.count),   32'(model_q.size()));
    chk({tag, ".empty"},   32'(bus.empty),   32'(model_q.size() == 0));
    chk({tag, ".full"},    32'(bus.full),    32'(model_q.size() == DEPTH));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(model_ovr));
    chk({tag, ".head"},    32'({bus.rd_fe, bus.rd_pe, bus.rd_data}), 32'(disp));
  endtask

  task automatic do_pop(input string tag);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    if (model_q.size() > 0) held = model_q.pop_front();
    check_state(tag);
  endtask

  task automatic do_ovr_clr(input string tag);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    model_ovr = 1'b0;
    check_state(tag);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe,
                            input bit stale, input bit pop_fetch, input string tag);
    int start;
    bit seen;
    start = rdn_lows;
    seen  = 1'b0;
    rx_byte          = d;
    bus.parity_error = pe;
    bus.frame_error  = fe;
    bus.no_bits_rcvd = 4'd11;
    bus.r_ready      = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (rdn_lows != start) seen = 1'b1;
    end
    chk({tag, ".fetch_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      bus.r_ready      = 1'b0;
      bus.no_bits_rcvd = 4'd0;
      return;
    end
    if (pop_fetch) bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    if (pop_fetch && model_q.size() > 0) held = model_q.pop_front();
    if (model_q.size() < DEPTH) model_q.push_back({fe, pe, d});
    else model_ovr = 1'b1;
    if (stale) begin
      bus.r_ready = 1'b1;
      repeat (3) tick();
    end
    bus.no_bits_rcvd = 4'd0;
    repeat (4) tick();
    chk({tag, ".rdn_pulses"}, 32'(rdn_lows - start), stale ? 32'd2 : 32'd1);
    check_state(tag);
  endtask

  initial begin
    bus.r_ready      = 1'b0;
    bus.parity_error = 1'b0;
    bus.frame_error  = 1'b0;
    bus.no_bits_rcvd = 4'd0;
    bus.rd_en        = 1'b0;
    bus.ovr_clr      = 1'b0;

    repeat (3) tick();
    chk("reset.rdn", 32'(bus.rdn), 32'd1);
    check_state("reset");
    clr = 1'b0;
    tick();

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "clean");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, "errored");
    do_pop("pop_a5");
    do_pop("pop_3c");
    do_pop("pop_empty");

    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, "stale");
    do_pop("pop_stale");

    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "fill");
    for (int i = 0; i < 16; i++) do_pop("drain");
    do_ovr_clr("ovr_clr");

    for (int i = 0; i < 16; i++)
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, "refill");
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, "full_pop_push");
    for (int i = 0; i < 16; i++) do_pop("drain2");

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)
        send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rand_frame");
      else if (sel <= 8)
        do_pop("rand_pop");
      else
        do_ovr_clr("rand_ovr_clr");
    end

    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset");
    begin
      int start;
      bit seen;
      start = rdn_lows;
      seen  = 1'b0;
      rx_byte          = 8'h99;
      bus.no_bits_rcvd = 4'd11;
      bus.r_ready      = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        if (rdn_lows != start) seen = 1'b1;
      end
      chk("midreset.fetch_seen", 32'(seen), 32'd1);
      clr = 1'b1;
      #1;
      chk("midreset.rdn",   32'(bus.rdn),   32'd1);
      chk("midreset.count", 32'(bus.count), 32'd0);
      chk("midreset.empty", 32'(bus.empty), 32'd1);
      bus.r_ready      = 1'b0;
      bus.no_bits_rcvd = 4'd0;
      tick();
      clr = 1'b0;
      model_q.delete();
      model_ovr = 1'b0;
      held      = 10'h000;
      tick();
      check_state("after_reset");
    end
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
    do_pop("post_reset_pop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
